branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
Program-flow controller for the Harvard Architecture Processor. It owns the 8-bit PC and fetches 16-bit instructions from instruction memory over a req/ack handshake. It resolves branch-class opcodes itself, using register-file read ports for R1/R2, and hands every non-branch instruction to the execute unit via valid/done, advancing the PC when that completes. It sits between instruction memory, the register file and the execute datapath.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
DW, 8, register data width; PC width is fixed at 8

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_rd  out  1  fetch request, held until imem_ack
imem_addr  out  8  fetch address, equals pc while imem_rd is high
imem_ack  in  1  fetch data valid this cycle
imem_data  in  16  instruction word
rf_addr_a  out  3  register-file read address A, from IR[10:8] (R1)
rf_addr_b  out  3  register-file read address B, from IR[2:0] (R2)
rf_data_a  in  DW  combinational read data A
rf_data_b  in  DW  combinational read data B
ex_valid  out  1  non-branch instruction offered to execute unit
ex_instr  out  16  instruction word, stable while ex_valid is high
ex_done  in  1  execute unit finished
pc  out  8  current PC
halted  out  1  HALT retired

Behaviour:
- Instruction fields: opcode = IR[15:11], R1 = IR[10:8], M = IR[7:0], R2 = IR[2:0].
- Branch opcodes:
  - JMP 5'b10000: pc <= M.
  - BZ 5'b10001: if R1 == 0, pc <= M; else pc + 1.
  - BNZ 5'b10010: if R1 != 0, pc <= M; else pc + 1.
  - SKE 5'b10011: if R1 == R2, pc <= pc + 2; else pc + 1.
  - JR 5'b10100: pc <= R1[7:0], zero-extended if DW < 8.
  - HALT 5'b11111.
- Every other opcode is non-branch.
- FSM states: FETCH, DECODE, REGRD, RESOLVE, EXEC, HALT.
- FETCH:
  - imem_rd = 1 and imem_addr = pc.
  - On imem_ack, IR <= imem_data and the next state is DECODE.
  - If imem_ack arrives in the first cycle of imem_rd, it is accepted, so minimum fetch = 1 cycle.
- DECODE (1 cycle):
  - JMP -> RESOLVE.
  - BZ, BNZ, SKE, JR -> REGRD.
  - HALT -> HALT.
  - Anything else -> EXEC.
- REGRD (1 cycle): rf_addr_a/b are driven from IR; rf_data_a/b are captured into regA/regB; next state is RESOLVE.
- RESOLVE (1 cycle): pc is updated per the table above; next state is FETCH.
  - Resulting branch latency: fetch + 3 cycles, or fetch + 2 cycles for JMP.
- EXEC:
  - ex_valid = 1 and ex_instr = IR, held until ex_done.
  - In the ex_done cycle, pc <= pc + 1, ex_valid drops on the next edge, and the next state is FETCH.
  - ex_done while ex_valid is low is ignored.
- HALT: halted = 1; the FSM stays in HALT until reset; imem_rd and ex_valid are held at 0.
- PC arithmetic is modulo 256:
  - 8'hFF + 1 -> 8'h00.
  - SKE at 8'hFF -> 8'h01.
  - SKE at 8'hFE -> 8'h00.
- Reset:
  - On any edge with rst_n = 0: pc = RESET_PC, state = FETCH, IR = 0, regA/regB = 0, imem_rd = 0, ex_valid = 0, ex_instr = 0, halted = 0.
  - imem_rd is registered, so it first rises in the cycle after reset deasserts.
  - Reset overrides any in-flight fetch or EXEC handshake. A pending ack or done that arrives after reset is ignored unless the FSM is in the matching state.
- rf_addr_a/b are combinational from IR and are 0 after reset.

Decomposition:
- Shared package hap_pkg holds:
  - opcode localparams: OP_JMP, OP_BZ, OP_BNZ, OP_SKE, OP_JR, OP_HALT
  - the state enum/encoding
  - field slice constants
  - instruction width 16 and PC width 8
- One natural sub-module: branch_resolve, purely combinational. Inputs are opcode, pc, M, regA and regB; output is next_pc.
- The FSM and handshakes stay in branch_sequencer.

Test Plan:
- Reset, then imem returns JMP 8'h40 (16'h8040) with ack on the first request -> imem_addr=00; after resolve pc=8'h40 and next imem_addr=8'h40.
- BZ R3,8'h20 (16'h8B20) with rf_data_a=0 -> pc=8'h20; repeat with rf_data_a=5 -> pc=old+1.
- SKE R1,R2 at pc=8'hFE (16'h9902) with rf_data_a = rf_data_b = 8'h7 -> pc=8'h00; with rf_data_b=8'h6 -> pc=8'hFF.
- Non-branch 16'h1234 at pc=8'h10, with ex_done held low for 4 cycles -> ex_valid and ex_instr=16'h1234 stable for 4 cycles; pc=8'h11 after done; no imem_rd during EXEC.
- Fetch with imem_ack delayed 3 cycles, then rst_n=0 for one cycle mid-wait -> imem_rd=0 and pc=RESET_PC next edge; a late ack while imem_rd=0 changes nothing.
- HALT 16'hF800 -> halted=1; imem_rd and ex_valid stay 0 for 20 cycles; pc frozen; reset clears halted.

Source files
------------

// File: rtl/hap_pkg.sv
// hap_pkg: shared opcodes, instruction field positions and sequencer states
package hap_pkg;
  localparam int IW = 16;
  localparam int PW = 8;
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam int R1_HI = 10;
  localparam int R1_LO = 8;
  localparam int M_HI = 7;
  localparam int M_LO = 0;
  localparam int R2_HI = 2;
  localparam int R2_LO = 0;
  localparam logic [4:0] OP_JMP = 5'b10000;
  localparam logic [4:0] OP_BZ = 5'b10001;
  localparam logic [4:0] OP_BNZ = 5'b10010;
  localparam logic [4:0] OP_SKE = 5'b10011;
  localparam logic [4:0] OP_JR = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11111;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_REGRD, S_RESOLVE, S_EXEC, S_HALT} state_t;
endpackage

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: instruction fetch, register read and execute handshakes
interface branch_sequencer_if import hap_pkg::*; #(parameter int DW = 8);
  logic imem_rd;
  logic [PW-1:0] imem_addr;
  logic imem_ack;
  logic [IW-1:0] imem_data;
  logic [2:0] rf_addr_a;
  logic [2:0] rf_addr_b;
  logic [DW-1:0] rf_data_a;
  logic [DW-1:0] rf_data_b;
  logic ex_valid;
  logic [IW-1:0] ex_instr;
  logic ex_done;
  logic [PW-1:0] pc;
  logic halted;
  modport master (
    output imem_rd, imem_addr, rf_addr_a, rf_addr_b, ex_valid, ex_instr, pc, halted,
    input imem_ack, imem_data, rf_data_a, rf_data_b, ex_done
  );
  modport slave (
    input imem_rd, imem_addr, rf_addr_a, rf_addr_b, ex_valid, ex_instr, pc, halted,
    output imem_ack, imem_data, rf_data_a, rf_data_b, ex_done
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: next pc for a branch-class opcode, all arithmetic modulo 256
module branch_resolve import hap_pkg::*; #(
  parameter int DW = 8
) (
  input  logic [4:0]    op,
  input  logic [PW-1:0] pc,
  input  logic [PW-1:0] m,
  input  logic [DW-1:0] rega,
  input  logic [DW-1:0] regb,
  output logic [PW-1:0] next_pc
);
  logic [PW-1:0] inc1;
  logic [PW-1:0] inc2;
  always_comb begin
    inc1 = pc + 8'd1;
    inc2 = pc + 8'd2;
    next_pc = op == OP_JMP ? m :
              op == OP_BZ  ? (rega == '0 ? m : inc1) :
              op == OP_BNZ ? (rega != '0 ? m : inc1) :
              op == OP_SKE ? (rega == regb ? inc2 : inc1) :
              op == OP_JR  ? 8'(rega) : inc1;
  end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: owns the pc, fetches instructions, resolves branches, dispatches the rest
module branch_sequencer import hap_pkg::*; #(
  parameter logic [PW-1:0] RESET_PC = 8'h00,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst_n,
  branch_sequencer_if.master bus
);
  state_t state, next_state;
  logic [IW-1:0] ir;
  logic [DW-1:0] rega, regb;
  logic [PW-1:0] pc, next_pc;
  logic [4:0] op;
  logic fetch_ok, done_ok, is_reg;
  assign op = ir[OP_HI:OP_LO];
  assign is_reg = op == OP_BZ || op == OP_BNZ || op == OP_SKE || op == OP_JR;
  // imem_rd/ex_valid are registered, so a handshake only counts once the request is visible
  assign fetch_ok = state == S_FETCH && bus.imem_rd && bus.imem_ack;
  assign done_ok = state == S_EXEC && bus.ex_valid && bus.ex_done;
  branch_resolve #(.DW(DW)) u_resolve (
    .op(op),
    .pc(pc),
    .m(ir[M_HI:M_LO]),
    .rega(rega),
    .regb(regb),
    .next_pc(next_pc)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      rega <= '0;
      regb <= '0;
      bus.imem_rd <= 1'b0;
      bus.ex_valid <= 1'b0;
      bus.ex_instr <= '0;
      bus.halted <= 1'b0;
    end else begin
      state <= next_state;
      bus.imem_rd <= next_state == S_FETCH;
      bus.ex_valid <= next_state == S_EXEC;
      bus.halted <= next_state == S_HALT;
      if (next_state == S_EXEC) bus.ex_instr <= ir;
      if (fetch_ok) ir <= bus.imem_data;
      if (state == S_REGRD) begin
        rega <= bus.rf_data_a;
        regb <= bus.rf_data_b;
      end
      if (state == S_RESOLVE) pc <= next_pc;
      else if (done_ok) pc <= pc + 8'd1;
    end
  end
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   next_state = fetch_ok ? S_DECODE : S_FETCH;
      S_DECODE:  next_state = op == OP_JMP ? S_RESOLVE : op == OP_HALT ? S_HALT : is_reg ? S_REGRD : S_EXEC;
      S_REGRD:   next_state = S_RESOLVE;
      S_RESOLVE: next_state = S_FETCH;
      S_EXEC:    next_state = done_ok ? S_FETCH : S_EXEC;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_FETCH;
    endcase
  end
  always_comb begin
    bus.imem_addr = pc;
    bus.pc = pc;
    bus.rf_addr_a = ir[R1_HI:R1_LO];
    bus.rf_addr_b = ir[R2_HI:R2_LO];
  end
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: vector table with fetch/execute scoreboard plus reset and halt sequences
module tb_branch_sequencer;
  typedef struct {
    logic [7:0] start;
    logic [15:0] instr;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] exp_pc;
    logic is_ex;
    int ack_lat;
    int ex_lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  branch_sequencer_if #(.DW(8)) bus();
  branch_sequencer #(.RESET_PC(8'h00), .DW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [15:0] imem [256];
  logic [7:0] rf [8];
  logic resp_en = 1'b1;
  logic active = 1'b0;
  logic r_ack = 1'b0;
  logic man_ack = 1'b0;
  logic ex_done_r = 1'b0;
  logic [15:0] r_data = '0;
  logic [15:0] man_data = '0;
  int ack_lat = 0;
  int ex_lat = 0;
  int wcnt = 0;
  int ecnt = 0;
  logic [7:0] fq [$];
  logic [15:0] eq [$];
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [12];
  assign bus.imem_ack = resp_en ? r_ack : man_ack;
  assign bus.imem_data = resp_en ? r_data : man_data;
  assign bus.rf_data_a = rf[bus.rf_addr_a];
  assign bus.rf_data_b = rf[bus.rf_addr_b];
  assign bus.ex_done = ex_done_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not match scoreboard", name);
  endtask

  // memory and execute-unit models; they also pop and check the scoreboard
  always @(negedge clk) begin
    if (resp_en && bus.imem_rd) begin
      if (wcnt >= ack_lat) begin
        r_ack = 1'b1;
        r_data = imem[bus.imem_addr];
        wcnt = 0;
        if (active) begin
          if (fq.size() == 0) fail("extra_fetch");
          else chk("fetch_addr", 32'(bus.imem_addr), 32'(fq.pop_front()));
        end
      end else begin
        r_ack = 1'b0;
        wcnt++;
      end
    end else begin
      r_ack = 1'b0;
      wcnt = 0;
    end
    if (bus.ex_valid) begin
      if (active) begin
        if (eq.size() == 0) fail("extra_ex");
        else chk("ex_instr", 32'(bus.ex_instr), 32'(eq[0]));
        chk("no_fetch_in_ex", 32'(bus.imem_rd), 32'd0);
      end
      ecnt++;
      if (ecnt > ex_lat) begin
        ex_done_r = 1'b1;
        ecnt = 0;
        if (active && eq.size() != 0) void'(eq.pop_front());
      end else ex_done_r = 1'b0;
    end else begin
      ex_done_r = 1'b0;
      ecnt = 0;
    end
  end

  task automatic run_vec(input vec_t v);
    int cnt;
    @(negedge clk);
    rst_n = 1'b0;
    fq.delete();
    eq.delete();
    for (int i = 0; i < 8; i++) rf[i] = 8'hEE;
    rf[v.instr[2:0]] = v.rb;
    rf[v.instr[10:8]] = v.ra;
    ack_lat = v.ack_lat;
    ex_lat = v.ex_lat;
    if (v.start != 8'h00) begin
      imem[0] = 16'h8000 | 16'(v.start);
      fq.push_back(8'h00);
    end
    imem[v.start] = v.instr;
    fq.push_back(v.start);
    fq.push_back(v.exp_pc);
    if (v.is_ex) eq.push_back(v.instr);
    @(negedge clk);
    rst_n = 1'b1;
    active = 1'b1;
    cnt = 0;
    while (fq.size() != 0 && cnt < 80) begin
      @(negedge clk);
      cnt++;
    end
    if (fq.size() != 0) fail("fetch_timeout");
    if (eq.size() != 0) fail("ex_missing");
    active = 1'b0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    vecs[0]  = '{8'h00, 16'h8040, 8'h00, 8'h00, 8'h40, 1'b0, 0, 0};
    vecs[1]  = '{8'h10, 16'h8B20, 8'h00, 8'h00, 8'h20, 1'b0, 0, 0};
    vecs[2]  = '{8'h10, 16'h8B20, 8'h05, 8'h00, 8'h11, 1'b0, 2, 0};
    vecs[3]  = '{8'h30, 16'h9255, 8'h07, 8'h00, 8'h55, 1'b0, 0, 0};
    vecs[4]  = '{8'h30, 16'h9255, 8'h00, 8'h00, 8'h31, 1'b0, 1, 0};
    vecs[5]  = '{8'hFE, 16'h9902, 8'h07, 8'h07, 8'h00, 1'b0, 0, 0};
    vecs[6]  = '{8'hFE, 16'h9902, 8'h07, 8'h06, 8'hFF, 1'b0, 0, 0};
    vecs[7]  = '{8'hFF, 16'h9902, 8'h3C, 8'h3C, 8'h01, 1'b0, 0, 0};
    vecs[8]  = '{8'h50, 16'hA400, 8'h9A, 8'h00, 8'h9A, 1'b0, 0, 0};
    vecs[9]  = '{8'h10, 16'h1234, 8'h00, 8'h00, 8'h11, 1'b1, 0, 4};
    vecs[10] = '{8'hFF, 16'h2A5C, 8'h00, 8'h00, 8'h00, 1'b1, 3, 1};
    vecs[11] = '{8'hFF, 16'h8005, 8'h00, 8'h00, 8'h05, 1'b0, 0, 0};
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(bus.pc), 32'h00);
    chk("rst_imem_rd", 32'(bus.imem_rd), 32'd0);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ex_instr", 32'(bus.ex_instr), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_rf_addr_a", 32'(bus.rf_addr_a), 32'd0);
    chk("rst_rf_addr_b", 32'(bus.rf_addr_b), 32'd0);
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);
    // delayed fetch interrupted by reset, then a stale ack
    @(negedge clk);
    rst_n = 1'b0;
    resp_en = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rd_first_cycle", 32'(bus.imem_rd), 32'd1);
    man_data = 16'h8040;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    cnt = 0;
    while (!(bus.imem_rd && bus.imem_addr == 8'h40) && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("fetch_at_40", 32'(bus.imem_addr), 32'h40);
    repeat (2) @(negedge clk);
    chk("rd_held_wait", 32'(bus.imem_rd), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_imem_rd", 32'(bus.imem_rd), 32'd0);
    chk("mid_rst_pc", 32'(bus.pc), 32'h00);
    rst_n = 1'b1;
    man_data = 16'h9B20;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("late_ack_rd", 32'(bus.imem_rd), 32'd1);
    chk("late_ack_ir", 32'(bus.rf_addr_a), 32'd0);
    @(negedge clk);
    chk("late_ack_ignored", 32'(bus.imem_rd), 32'd1);
    chk("late_ack_pc", 32'(bus.pc), 32'h00);
    // halt
    rst_n = 1'b0;
    @(negedge clk);
    resp_en = 1'b1;
    ack_lat = 0;
    imem[0] = 16'h8033;
    imem[8'h33] = 16'hF800;
    rst_n = 1'b1;
    cnt = 0;
    while (!bus.halted && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_imem_rd", 32'(bus.imem_rd), 32'd0);
      chk("halt_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("halt_pc", 32'(bus.pc), 32'h33);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_clears_halted", 32'(bus.halted), 32'd0);
    chk("rst_after_halt_pc", 32'(bus.pc), 32'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
